// File: rtl/rsa_job_scheduler.sv
// Round-robin job scheduler for the shared RSA modular-exponentiation engine.
// Holds key/modulus registers, sequences the engine and returns tagged results.
module rsa_job_scheduler #(
  parameter int WordSize      = 8,
  parameter int LoadCycles    = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [WordSize-1:0] cfg_data,
  input  logic                enc_req,
  input  logic [WordSize-1:0] enc_text,
  output logic                enc_ack,
  input  logic                dec_req,
  input  logic [WordSize-1:0] dec_text,
  output logic                dec_ack,
  output logic                res_valid,
  output logic [WordSize-1:0] res_data,
  output logic                res_tag,
  output logic                res_err,
  input  logic                res_ready,
  output logic                busy,
  output logic                dp_reset,
  output logic                dp_load,
  output logic                dp_running,
  output logic [WordSize-1:0] dp_text,
  output logic [WordSize-1:0] dp_key,
  output logic [WordSize-1:0] dp_mod,
  input  logic [WordSize-1:0] dp_result,
  input  logic                dp_over
);

  localparam int CW = $clog2(TimeoutCycles);
  localparam logic [CW-1:0] TLAST = CW'(TimeoutCycles - 1);
  localparam logic [3:0] LLAST = 4'(LoadCycles - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic [WordSize-1:0] mod_q, mod_d, e_q, e_d, d_q, d_d;
  logic [WordSize-1:0] jtext_q, jtext_d, jkey_q, jkey_d, jmod_q, jmod_d;
  logic                tag_q, tag_d;
  logic [3:0]          lcnt_q, lcnt_d;
  logic [CW-1:0]       tcnt_q, tcnt_d;
  logic                enc_ack_q, enc_ack_d, dec_ack_q, dec_ack_d;
  logic                res_valid_q, res_valid_d, res_tag_q, res_tag_d;
  logic                res_err_q, res_err_d, busy_q, busy_d;
  logic [WordSize-1:0] res_data_q, res_data_d;
  logic                dp_reset_q, dp_reset_d, dp_load_q, dp_load_d;
  logic                dp_running_q, dp_running_d;
  logic [WordSize-1:0] dp_text_q, dp_text_d, dp_key_q, dp_key_d;
  logic [WordSize-1:0] dp_mod_q, dp_mod_d;
  logic                pick_dec;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    mod_d        = mod_q;
    e_d          = e_q;
    d_d          = d_q;
    jtext_d      = jtext_q;
    jkey_d       = jkey_q;
    jmod_d       = jmod_q;
    tag_d        = tag_q;
    lcnt_d       = lcnt_q;
    tcnt_d       = tcnt_q;
    enc_ack_d    = 1'b0;
    dec_ack_d    = 1'b0;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_err_d    = res_err_q;
    dp_reset_d   = 1'b0;
    dp_load_d    = dp_load_q;
    dp_running_d = dp_running_q;
    dp_text_d    = dp_text_q;
    dp_key_d     = dp_key_q;
    dp_mod_d     = dp_mod_q;
    // rr_q=1 favours decrypt when both channels request
    pick_dec     = dec_req && (!enc_req || rr_q);

    if (cfg_we) begin
      case (cfg_sel)
        2'd0:    mod_d = cfg_data;
        2'd1:    e_d   = cfg_data;
        2'd2:    d_d   = cfg_data;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (!res_valid_q && (enc_req || dec_req)) begin
          if (enc_req && dec_req) rr_d = ~rr_q;
          enc_ack_d  = ~pick_dec;
          dec_ack_d  = pick_dec;
          jtext_d    = pick_dec ? dec_text : enc_text;
          jkey_d     = pick_dec ? d_q : e_q;
          jmod_d     = mod_q;
          tag_d      = pick_dec;
          dp_reset_d = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        dp_load_d = 1'b1;
        dp_text_d = jtext_q;
        dp_key_d  = jkey_q;
        dp_mod_d  = jmod_q;
        lcnt_d    = 4'd0;
        state_d   = LOAD;
      end
      LOAD: begin
        if (lcnt_q == LLAST) begin
          dp_load_d    = 1'b0;
          dp_running_d = 1'b1;
          tcnt_d       = '0;
          state_d      = RUN;
        end else begin
          lcnt_d = lcnt_q + 4'd1;
        end
      end
      RUN: begin
        tcnt_d = tcnt_q + CW'(1);
        if (dp_over || tcnt_q == TLAST) begin
          res_data_d   = dp_over ? dp_result : '0;
          res_err_d    = ~dp_over;
          res_tag_d    = tag_q;
          res_valid_d  = 1'b1;
          dp_running_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      mod_q        <= '0;
      e_q          <= '0;
      d_q          <= '0;
      jtext_q      <= '0;
      jkey_q       <= '0;
      jmod_q       <= '0;
      tag_q        <= 1'b0;
      lcnt_q       <= '0;
      tcnt_q       <= '0;
      enc_ack_q    <= 1'b0;
      dec_ack_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= 1'b0;
      res_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      dp_reset_q   <= 1'b0;
      dp_load_q    <= 1'b0;
      dp_running_q <= 1'b0;
      dp_text_q    <= '0;
      dp_key_q     <= '0;
      dp_mod_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      mod_q        <= mod_d;
      e_q          <= e_d;
      d_q          <= d_d;
      jtext_q      <= jtext_d;
      jkey_q       <= jkey_d;
      jmod_q       <= jmod_d;
      tag_q        <= tag_d;
      lcnt_q       <= lcnt_d;
      tcnt_q       <= tcnt_d;
      enc_ack_q    <= enc_ack_d;
      dec_ack_q    <= dec_ack_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_err_q    <= res_err_d;
      busy_q       <= busy_d;
      dp_reset_q   <= dp_reset_d;
      dp_load_q    <= dp_load_d;
      dp_running_q <= dp_running_d;
      dp_text_q    <= dp_text_d;
      dp_key_q     <= dp_key_d;
      dp_mod_q     <= dp_mod_d;
    end
  end

  assign enc_ack    = enc_ack_q;
  assign dec_ack    = dec_ack_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign res_err    = res_err_q;
  assign busy       = busy_q;
  assign dp_reset   = dp_reset_q;
  assign dp_load    = dp_load_q;
  assign dp_running = dp_running_q;
  assign dp_text    = dp_text_q;
  assign dp_key     = dp_key_q;
  assign dp_mod     = dp_mod_q;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed bench for rsa_job_scheduler with a behavioural engine model
// and a result scoreboard filled at each grant.
module tb_rsa_job_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       enc_req, dec_req, enc_ack, dec_ack;
  logic [7:0] enc_text, dec_text;
  logic       res_valid, res_tag, res_err, res_ready, busy;
  logic [7:0] res_data;
  logic       dp_reset, dp_load, dp_running, dp_over;
  logic [7:0] dp_text, dp_key, dp_mod, dp_result;

  always #5 clk = ~clk;

  rsa_job_scheduler #(
    .WordSize(8), .LoadCycles(2), .TimeoutCycles(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .enc_req(enc_req), .enc_text(enc_text), .enc_ack(enc_ack),
    .dec_req(dec_req), .dec_text(dec_text), .dec_ack(dec_ack),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .res_err(res_err), .res_ready(res_ready), .busy(busy),
    .dp_reset(dp_reset), .dp_load(dp_load), .dp_running(dp_running),
    .dp_text(dp_text), .dp_key(dp_key), .dp_mod(dp_mod),
    .dp_result(dp_result), .dp_over(dp_over)
  );

  int checks = 0;
  int failures = 0;
  logic [9:0] sb[$];
  logic [7:0] cfg_mod_m, cfg_e_m, cfg_d_m;
  int eng_n = 5;
  bit eng_hang = 1'b0;
  int eng_cnt = 0;
  logic [7:0] m_text, m_key, m_mod;
  int last_run;

  function automatic logic [7:0] modexp(logic [7:0] b, logic [7:0] e,
                                        logic [7:0] m);
    int r;
    if (m == 8'd0) return 8'd0;
    r = 1 % int'(m);
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(m);
    return 8'(r);
  endfunction

  // engine: captures operands on load, raises over after eng_n running cycles
  always @(posedge clk) begin
    if (dp_load) begin
      m_text <= dp_text;
      m_key  <= dp_key;
      m_mod  <= dp_mod;
    end
    if (dp_running && !eng_hang) begin
      eng_cnt <= eng_cnt + 1;
      dp_over <= (eng_cnt + 1 == eng_n);
    end else begin
      eng_cnt <= 0;
      dp_over <= 1'b0;
    end
  end

  assign dp_result = dp_over ? modexp(m_text, m_key, m_mod) : 8'h5A;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input logic [1:0] sel, input logic [7:0] val);
    cfg_sel  = sel;
    cfg_data = val;
    cfg_we   = 1'b1;
    @(negedge clk);
    cfg_we   = 1'b0;
    case (sel)
      2'd0:    cfg_mod_m = val;
      2'd1:    cfg_e_m   = val;
      2'd2:    cfg_d_m   = val;
      default: ;
    endcase
  endtask

  task automatic wait_grant(output bit is_dec);
    bit got;
    logic [7:0] txt, exp;
    got = 1'b0;
    is_dec = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = enc_ack | dec_ack;
    end
    if (!got) begin
      check("grant_timeout", 32'(0), 32'(1));
      return;
    end
    is_dec = dec_ack;
    check("ack_onehot", 32'(enc_ack & dec_ack), 32'(0));
    txt = is_dec ? dec_text : enc_text;
    exp = eng_hang ? 8'd0
                   : modexp(txt, is_dec ? cfg_d_m : cfg_e_m, cfg_mod_m);
    sb.push_back({eng_hang, is_dec, exp});
    @(negedge clk);
    check("ack_pulse", 32'(enc_ack | dec_ack), 32'(0));
  endtask

  task automatic wait_valid();
    bit got;
    got = res_valid;
    last_run = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (dp_running) last_run++;
      @(negedge clk);
      got = res_valid;
    end
    if (!got) check("valid_timeout", 32'(0), 32'(1));
  endtask

  task automatic get_result();
    logic [9:0] e;
    wait_valid();
    if (!res_valid) return;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check("res_data", 32'(res_data), 32'(e[7:0]));
      check("res_tag", 32'(res_tag), 32'(e[8]));
      check("res_err", 32'(res_err), 32'(e[9]));
    end
    check("dp_running_done", 32'(dp_running), 32'(0));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_drop", 32'(res_valid), 32'(0));
  endtask

  task automatic setup_keys();
    write_cfg(2'd0, 8'd33);
    write_cfg(2'd1, 8'd7);
    write_cfg(2'd2, 8'd3);
  endtask

  initial begin
    bit d;
    bit ok;
    logic [7:0] d0;
    reset = 1'b1;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
    enc_req = 1'b0; dec_req = 1'b0; enc_text = 8'd0; dec_text = 8'd0;
    res_ready = 1'b0; dp_over = 1'b0;
    cfg_mod_m = 8'd0; cfg_e_m = 8'd0; cfg_d_m = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_acks", 32'({enc_ack, dec_ack}), 32'(0));
    check("rst_dp_ctl", 32'({dp_reset, dp_load, dp_running}), 32'(0));
    check("rst_dp_words", 32'({dp_text, dp_key, dp_mod}), 32'(0));
    check("rst_res_word", 32'({res_data, res_tag, res_err}), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    setup_keys();

    // encrypt 4 -> 16
    enc_text = 8'd4; enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    check("enc_grant_tag", 32'(d), 32'(0));
    check("busy_job", 32'(busy), 32'(1));
    check("dp_key_e", 32'(dp_key), 32'(7));
    get_result();
    check("busy_idle", 32'(busy), 32'(0));

    // decrypt 16 -> 4 (round trip)
    dec_text = 8'd16; dec_req = 1'b1;
    wait_grant(d);
    dec_req = 1'b0;
    check("dec_grant_tag", 32'(d), 32'(1));
    wait_valid();
    check("round_trip", 32'(res_data), 32'(4));
    get_result();

    // key written mid-job affects only the next job
    enc_text = 8'd5; enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    cfg_sel = 2'd1; cfg_data = 8'd3; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    get_result();
    cfg_e_m = 8'd3;
    enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    get_result();
    write_cfg(2'd1, 8'd7);

    // round robin with both channels requesting
    enc_text = 8'd4; dec_text = 8'd16;
    enc_req = 1'b1; dec_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(d);
      check("rr_order", 32'(d), 32'(i % 2));
      if (i == 3) begin
        enc_req = 1'b0; dec_req = 1'b0;
      end
      get_result();
    end

    // result slot held: no new grant while res_valid
    enc_text = 8'd2; enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    dec_text = 8'd16; dec_req = 1'b1;
    wait_valid();
    d0 = res_data;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_data === d0 && busy === 1'b1 &&
            enc_ack === 1'b0 && dec_ack === 1'b0)) ok = 1'b0;
    end
    check("stall_stable", 32'(ok), 32'(1));
    get_result();
    wait_grant(d);
    dec_req = 1'b0;
    check("after_stall_tag", 32'(d), 32'(1));
    get_result();

    // over coinciding with the timeout cycle is a normal result
    eng_n = 15;
    enc_text = 8'd4; enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    get_result();
    eng_n = 5;

    // engine never finishes: abort after 16 run cycles
    eng_hang = 1'b1;
    enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    get_result();
    check("timeout_run_cycles", 32'(last_run), 32'(16));
    eng_hang = 1'b0;

    // ready already high when DONE is entered
    res_ready = 1'b1;
    dec_text = 8'd16; dec_req = 1'b1;
    wait_grant(d);
    dec_req = 1'b0;
    get_result();

    // reset mid-run abandons the job
    enc_text = 8'd4; enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = dp_running;
    end
    check("reached_run", 32'(ok), 32'(1));
    reset = 1'b1;
    #1;
    check("midrst_ctl", 32'({res_valid, busy, dp_running, dp_load}),
          32'(0));
    check("midrst_words", 32'({dp_text, dp_key, dp_mod, res_data}), 32'(0));
    if (sb.size() > 0) void'(sb.pop_back());
    repeat (3) @(negedge clk);
    check("midrst_no_result", 32'(res_valid), 32'(0));
    reset = 1'b0;
    cfg_mod_m = 8'd0; cfg_e_m = 8'd0; cfg_d_m = 8'd0;
    @(negedge clk);
    setup_keys();
    enc_req = 1'b1;
    wait_grant(d);
    enc_req = 1'b0;
    check("post_rst_tag", 32'(d), 32'(0));
    get_result();

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
